// File: rtl/mem_seq_ctrl_pkg.sv
// Shared definitions for the memory sequencer: state encodings and the reset instruction.
package mem_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_DATA   = 3'd2,
      ST_COMMIT = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   function automatic logic is_req_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_DATA);
   endfunction

endpackage

// File: rtl/mem_seq_ctrl_ack_watchdog.sv
// Ack watchdog: counts non-ack request cycles and flags the cycle in which the count
// would reach all-ones, so an ack in that same cycle still wins.
module ack_watchdog #(
   parameter int TMO_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_timeout
);

   localparam logic [TMO_W-1:0] LAST_WAIT = {TMO_W{1'b1}} - TMO_W'(1);

   logic [TMO_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count_en) begin
         r_count <= r_count + TMO_W'(1);
      end
   end

   assign o_timeout = i_count_en && (r_count == LAST_WAIT);

endmodule

// File: rtl/mem_seq_ctrl.sv
// Sequencer sharing one variable-latency single-port memory between instruction fetch and
// load/store; FETCH -> DECODE -> (DATA) -> COMMIT with a watchdog-driven sticky error.
module mem_seq_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int TMO_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] inst_out,
   output logic [DATA_W-1:0] ld_data,
   output logic              commit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bus_err,
   output logic [31:0]       instret
);

   import mem_seq_ctrl_pkg::*;

   state_t            r_state;
   state_t            w_state_next;
   logic [DATA_W-1:0] r_inst;
   logic [DATA_W-1:0] r_ld;
   logic              r_err;
   logic [31:0]       r_instret;

   logic              w_in_req;
   logic              w_timeout;
   logic              w_req;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic              w_inst_load;
   logic              w_ld_load;
   logic              w_set_err;

   assign w_in_req = is_req_state(r_state);

   ack_watchdog #(
      .TMO_W (TMO_W)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (!w_in_req),
      .i_count_en (w_in_req && !mem_ack),
      .o_timeout  (w_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_inst    <= DATA_W'(NOP_INST);
         r_ld      <= '0;
         r_err     <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_inst_load) begin
            r_inst <= mem_rdata;
         end
         if (w_ld_load) begin
            r_ld <= mem_rdata;
         end
         if (w_set_err) begin
            r_err <= 1'b1;
         end
         if (r_state == ST_COMMIT) begin
            r_instret <= r_instret + 32'd1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_we         = 1'b0;
      w_addr       = pc_in;
      w_inst_load  = 1'b0;
      w_ld_load    = 1'b0;
      w_set_err    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_req = 1'b1;
            if (mem_ack) begin
               w_inst_load  = 1'b1;
               w_state_next = ST_DECODE;
            end else if (w_timeout) begin
               w_set_err    = 1'b1;
               w_state_next = ST_ERROR;
            end
         end
         ST_DECODE: begin
            w_state_next = d_req ? ST_DATA : ST_COMMIT;
         end
         ST_DATA: begin
            w_req  = 1'b1;
            w_we   = d_we;
            w_addr = d_addr;
            if (mem_ack) begin
               w_ld_load    = !d_we;
               w_state_next = ST_COMMIT;
            end else if (w_timeout) begin
               w_set_err    = 1'b1;
               w_state_next = ST_ERROR;
            end
         end
         ST_COMMIT: begin
            w_state_next = ST_FETCH;
         end
         ST_ERROR: begin
            w_state_next = ST_ERROR;
         end
         default: begin
            w_state_next = ST_ERROR;
         end
      endcase
   end

   // Reset forces the state to FETCH, so gate the request directly to abandon the transaction.
   assign mem_req   = w_req && !rst;
   assign mem_we    = w_we && !rst;
   assign mem_addr  = w_addr;
   assign mem_wdata = d_wdata;

   assign inst_out = r_inst;
   assign ld_data  = r_ld;
   assign commit   = (r_state == ST_COMMIT);
   assign bus_err  = r_err;
   assign instret  = r_instret;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: scripted memory, per-instruction timeline model checked every
// cycle, plus directed literal checks for each scenario.
module tb_mem_seq_ctrl;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [31:0] IDLE_DATA = 32'hBAD0_BAD0;
   localparam int          TMO_LIMIT = 255;

   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_DATA   = 2;
   localparam int P_COMMIT = 3;
   localparam int P_DEAD   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_in = '0;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] inst_out;
   logic [31:0] ld_data;
   logic        commit;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = IDLE_DATA;
   logic        bus_err;
   logic [31:0] instret;

   int          checks = 0;
   int          failures = 0;

   int          lat_fetch = 0;
   int          lat_data = 0;
   logic [31:0] fetch_word = NOP;
   logic [31:0] load_word = '0;
   logic        pc_step = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   int          st_count = 0;

   always #5 clk = ~clk;

   mem_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .pc_in     (pc_in),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .inst_out  (inst_out),
      .ld_data   (ld_data),
      .commit    (commit),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .bus_err   (bus_err),
      .instret   (instret)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Datapath pc stepping and a memory that acks after a scripted number of wait cycles.
   initial begin : mem_drv
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) pc_in = '0;
         else if (pc_step) pc_in = pc_in + 32'd4;
         #1;
         if (mem_req) begin
            mem_ack = (cnt == ((mem_addr == pc_in) ? lat_fetch : lat_data));
            cnt++;
            if (mem_ack) begin
               mem_rdata = (mem_addr == pc_in) ? fetch_word : load_word;
               if (mem_we) begin
                  st_addr = mem_addr;
                  st_data = mem_wdata;
                  st_count++;
               end
            end else begin
               mem_rdata = IDLE_DATA;
            end
         end else begin
            cnt       = 0;
            mem_ack   = 1'b0;
            mem_rdata = IDLE_DATA;
         end
      end
   end

   // Timeline model: which step of the instruction we are in, how long the current
   // access has waited, and what the latched values must be.
   initial begin : model
      int          ph;
      int          waited;
      logic [31:0] m_inst;
      logic [31:0] m_ld;
      logic [31:0] m_ret;
      logic        m_err;
      logic        exp_req;
      ph = P_FETCH; waited = 0; m_inst = NOP; m_ld = '0; m_ret = '0; m_err = 1'b0;
      forever begin
         @(negedge clk);
         pc_step = commit;
         if (rst) begin
            check("rst_mem_req", {31'd0, mem_req}, 32'd0);
            check("rst_commit", {31'd0, commit}, 32'd0);
            check("rst_bus_err", {31'd0, bus_err}, 32'd0);
            check("rst_instret", instret, 32'd0);
            check("rst_inst_out", inst_out, NOP);
            check("rst_ld_data", ld_data, 32'd0);
            ph = P_FETCH; waited = 0; m_inst = NOP; m_ld = '0; m_ret = '0; m_err = 1'b0;
         end else begin
            exp_req = (ph == P_FETCH) || (ph == P_DATA);
            check("cyc_mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            check("cyc_commit", {31'd0, commit}, {31'd0, ph == P_COMMIT});
            check("cyc_inst_out", inst_out, m_inst);
            check("cyc_ld_data", ld_data, m_ld);
            check("cyc_instret", instret, m_ret);
            check("cyc_bus_err", {31'd0, bus_err}, {31'd0, m_err});
            if (exp_req) begin
               check("cyc_mem_we", {31'd0, mem_we}, {31'd0, (ph == P_DATA) && d_we});
               check("cyc_mem_addr", mem_addr, (ph == P_FETCH) ? pc_in : d_addr);
               if (ph == P_DATA && d_we) check("cyc_mem_wdata", mem_wdata, d_wdata);
            end
            case (ph)
               P_FETCH, P_DATA: begin
                  if (mem_ack) begin
                     if (ph == P_FETCH) m_inst = mem_rdata;
                     else if (!d_we) m_ld = mem_rdata;
                     ph = (ph == P_FETCH) ? P_DECODE : P_COMMIT;
                  end else begin
                     waited++;
                     if (waited == TMO_LIMIT) begin
                        m_err = 1'b1;
                        ph    = P_DEAD;
                     end
                  end
               end
               P_DECODE: begin
                  ph     = d_req ? P_DATA : P_COMMIT;
                  waited = 0;
               end
               P_COMMIT: begin
                  m_ret  = m_ret + 32'd1;
                  ph     = P_FETCH;
                  waited = 0;
               end
               default: ph = P_DEAD;
            endcase
         end
      end
   end

   task automatic run_to_commit(input int limit, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!commit && cyc < limit);
      check("commit_seen", {31'd0, commit}, 32'd1);
   endtask

   initial begin : stim
      int          cyc;
      int          ncommit;
      int          nreq;
      int          first_err;
      logic [31:0] addrs [3];
      addrs = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("lit_rst_inst", inst_out, 32'h0000_0013);
      check("lit_rst_req", {31'd0, mem_req}, 32'd0);
      check("lit_rst_instret", instret, 32'd0);
      rst = 1'b0;

      // NOP stream, zero-wait memory
      ncommit = 0; nreq = 0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (mem_req) begin
            if (nreq < 3) addrs[nreq] = mem_addr;
            nreq++;
         end
         if (commit) begin
            check("nop_commit_phase", c % 3, 32'd0);
            ncommit++;
         end
      end
      check("nop_commits", ncommit, 32'd3);
      check("nop_fetches", nreq, 32'd3);
      check("nop_pc0", addrs[0], 32'd0);
      check("nop_pc1", addrs[1], 32'd4);
      check("nop_pc2", addrs[2], 32'd8);
      @(posedge clk);
      #1;
      check("nop_instret", instret, 32'd3);
      $display("txn nop_stream commits=%0d instret=%0d", ncommit, instret);

      // Load with two wait cycles
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; lat_data = 2;
      fetch_word = 32'h1000_2083; load_word = 32'hDEAD_BEEF;
      run_to_commit(20, cyc);
      check("load_cycles", cyc, 32'd6);
      check("load_ld_data", ld_data, 32'hDEAD_BEEF);
      check("load_inst", inst_out, 32'h1000_2083);
      $display("txn load addr=0x100 cycles=%0d ld_data=%h", cyc, ld_data);

      // Store with three wait cycles
      d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678; lat_data = 3;
      fetch_word = 32'h0020_2223;
      run_to_commit(20, cyc);
      check("store_cycles", cyc, 32'd7);
      check("store_ld_kept", ld_data, 32'hDEAD_BEEF);
      check("store_count", st_count, 32'd1);
      check("store_addr", st_addr, 32'h104);
      check("store_data", st_data, 32'h1234_5678);
      $display("txn store addr=%h data=%h cycles=%0d", st_addr, st_data, cyc);

      // Ack on the terminal watchdog cycle
      d_we = 1'b0; d_addr = 32'h108; lat_data = 254;
      fetch_word = 32'h0080_2103; load_word = 32'hCAFE_F00D;
      run_to_commit(400, cyc);
      check("late_ack_cycles", cyc, 32'd258);
      check("late_ack_ld", ld_data, 32'hCAFE_F00D);
      check("late_ack_no_err", {31'd0, bus_err}, 32'd0);
      $display("txn late_ack cycles=%0d bus_err=%0b", cyc, bus_err);

      // Reset in the middle of a slow fetch
      d_req = 1'b0; lat_fetch = 5; fetch_word = 32'h0000_0073;
      repeat (2) @(negedge clk);
      check("midrst_req_before", {31'd0, mem_req}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_req_drop", {31'd0, mem_req}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_inst_nop", inst_out, NOP);
      check("midrst_instret", instret, 32'd0);
      check("midrst_req_restart", {31'd0, mem_req}, 32'd1);
      run_to_commit(30, cyc);
      check("midrst_cycles", cyc, 32'd8);
      check("midrst_inst", inst_out, 32'h0000_0073);
      @(posedge clk);
      #1;
      check("midrst_instret_after", instret, 32'd1);
      $display("txn reset_mid_fetch cycles=%0d instret=%0d", cyc, instret);

      // Data access that never acks
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10C; lat_fetch = 0; lat_data = 100000;
      ncommit = 0; first_err = 0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (commit) ncommit++;
         if (bus_err && first_err == 0) first_err = c;
      end
      check("tmo_no_commit", ncommit, 32'd0);
      check("tmo_err_cycle", first_err, 32'd258);
      check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
      check("tmo_req_low", {31'd0, mem_req}, 32'd0);
      $display("txn timeout err_cycle=%0d commits=%0d", first_err, ncommit);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("tmo_rst_clears", {31'd0, bus_err}, 32'd0);
      $display("txn reset_after_error bus_err=%0b", bus_err);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
